// File: rtl/fuzz_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fuzz_round_sequencer
// Description : Sequences fuzzing rounds around the DUT. It gates the DUT
//               clock, drives DUT reset, handshakes with the coverage
//               collector and memory reloader, and raises a stall/watchdog irq.
// Revision    : 1.0 - initial release
// ============================================================================
module fuzz_round_sequencer #(
  parameter int unsigned COV_W        = 30,
  parameter int unsigned STALL_LIMIT  = 1000,
  parameter int unsigned WDOG_LIMIT   = 10000,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned RESET_CYCLES = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             fuzz_en,
  input  logic [63:0]      max_cycles,
  input  logic [63:0]      tohost,
  input  logic [COV_W-1:0] cov,
  output logic             dut_clk_en,
  output logic             dut_reset,
  output logic             irq,
  output logic             col_req,
  output logic [COV_W-1:0] col_cov,
  input  logic             col_ack,
  input  logic             col_next,
  output logic             load_req,
  input  logic             load_ack,
  output logic             done,
  output logic             fail,
  output logic [31:0]      round_cnt
);

  localparam logic [2:0] c_RESET   = 3'd0;
  localparam logic [2:0] c_RUN     = 3'd1;
  localparam logic [2:0] c_DRAIN   = 3'd2;
  localparam logic [2:0] c_COLLECT = 3'd3;
  localparam logic [2:0] c_LOAD    = 3'd4;
  localparam logic [2:0] c_DONE    = 3'd5;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [31:0]      r_hold_cnt;
  logic [63:0]      r_run_cnt;
  logic [31:0]      r_wdog_cnt;
  logic [31:0]      r_stall_cnt;
  logic [COV_W-1:0] r_cov_prev;
  logic             r_fail_rec;

  logic [31:0]      w_hold_inc;
  logic [63:0]      w_run_inc;
  logic [31:0]      w_wdog_inc;
  logic [31:0]      w_stall_inc;
  logic             w_timeout;
  logic             w_reset_end;
  logic             w_drain_end;
  logic             w_unused;

  assign w_unused    = ^tohost[63:1];
  assign w_hold_inc  = r_hold_cnt + 32'd1;
  assign w_run_inc   = (&r_run_cnt)   ? r_run_cnt   : r_run_cnt + 64'd1;
  assign w_wdog_inc  = (&r_wdog_cnt)  ? r_wdog_cnt  : r_wdog_cnt + 32'd1;
  assign w_stall_inc = (&r_stall_cnt) ? r_stall_cnt : r_stall_cnt + 32'd1;
  // Timeout compares against the count including the current cycle.
  assign w_timeout   = (max_cycles != 64'd0) && (w_run_inc > max_cycles);
  assign w_reset_end = (w_hold_inc >= RESET_CYCLES);
  assign w_drain_end = (w_hold_inc >= DRAIN_CYCLES);

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_RESET:   if (w_reset_end) w_next = c_RUN;
      c_RUN:     if (tohost[0] || w_timeout) w_next = c_DRAIN;
      c_DRAIN:   if (w_drain_end) w_next = (r_fail_rec || !fuzz_en) ? c_DONE : c_COLLECT;
      c_COLLECT: if (col_ack) w_next = col_next ? c_LOAD : c_RESET;
      c_LOAD:    if (load_ack) w_next = c_RESET;
      c_DONE:    w_next = c_DONE;
      default:   w_next = c_RESET;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= c_RESET;
      r_hold_cnt  <= '0;
      r_run_cnt   <= '0;
      r_wdog_cnt  <= '0;
      r_stall_cnt <= '0;
      r_cov_prev  <= '0;
      r_fail_rec  <= 1'b0;
      dut_clk_en  <= 1'b1;
      dut_reset   <= 1'b1;
      irq         <= 1'b0;
      col_req     <= 1'b0;
      col_cov     <= '0;
      load_req    <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      round_cnt   <= '0;
    end else begin
      r_state <= w_next;

      if (w_next == r_state && (r_state == c_RESET || r_state == c_DRAIN))
        r_hold_cnt <= w_hold_inc;
      else
        r_hold_cnt <= '0;

      // Progress counters live only inside a round; the coverage baseline
      // tracks cov outside RUN so the first run cycle compares fairly.
      if (r_state == c_RUN && w_next == c_RUN) begin
        r_run_cnt  <= w_run_inc;
        r_wdog_cnt <= w_wdog_inc;
        if (cov == r_cov_prev) begin
          r_stall_cnt <= w_stall_inc;
        end else begin
          r_stall_cnt <= '0;
          r_cov_prev  <= cov;
        end
      end else begin
        r_run_cnt   <= '0;
        r_wdog_cnt  <= '0;
        r_stall_cnt <= '0;
        r_cov_prev  <= cov;
      end

      if (r_state == c_RUN && w_next == c_DRAIN)
        r_fail_rec <= ~tohost[0];

      irq <= (w_next == c_RUN) &&
             ((r_stall_cnt >= STALL_LIMIT) || (r_wdog_cnt >= WDOG_LIMIT));

      dut_clk_en <= (w_next == c_RESET) || (w_next == c_RUN);
      dut_reset  <= (w_next == c_RESET) || (w_next == c_LOAD);
      col_req    <= (w_next == c_COLLECT);
      load_req   <= (w_next == c_LOAD);
      done       <= (w_next == c_DONE);

      if (r_state == c_DRAIN && w_next == c_DONE)
        fail <= r_fail_rec;
      if (r_state == c_DRAIN && w_next == c_COLLECT)
        col_cov <= cov;
      if (r_state == c_COLLECT && col_ack)
        round_cnt <= round_cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fuzz_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fuzz_round_sequencer
// Description : Directed/randomized self-checking bench for fuzz_round_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fuzz_round_sequencer;

  localparam int COV_W        = 30;
  localparam int STALL_LIMIT  = 1000;
  localparam int WDOG_LIMIT   = 10000;
  localparam int DRAIN_CYCLES = 4;
  localparam int RESET_CYCLES = 8;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             fuzz_en = 1'b1;
  logic [63:0]      max_cycles = '0;
  logic [63:0]      tohost = '0;
  logic [COV_W-1:0] cov = '0;
  logic             col_ack = 1'b0;
  logic             col_next = 1'b0;
  logic             load_ack = 1'b0;
  logic             dut_clk_en, dut_reset, irq, col_req, load_req, done, fail;
  logic [COV_W-1:0] col_cov;
  logic [31:0]      round_cnt;

  int total = 0;
  int bad = 0;
  int exp_rounds = 0;

  always #5 clock = ~clock;

  fuzz_round_sequencer #(
    .COV_W(COV_W), .STALL_LIMIT(STALL_LIMIT), .WDOG_LIMIT(WDOG_LIMIT),
    .DRAIN_CYCLES(DRAIN_CYCLES), .RESET_CYCLES(RESET_CYCLES)
  ) dut (
    .clock(clock), .reset_n(reset_n), .fuzz_en(fuzz_en), .max_cycles(max_cycles),
    .tohost(tohost), .cov(cov), .dut_clk_en(dut_clk_en), .dut_reset(dut_reset),
    .irq(irq), .col_req(col_req), .col_cov(col_cov), .col_ack(col_ack),
    .col_next(col_next), .load_req(load_req), .load_ack(load_ack),
    .done(done), .fail(fail), .round_cnt(round_cnt)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // RESET phase just begun: dut_reset must hold for exactly RESET_CYCLES edges.
  task automatic check_reset_phase(input string tag);
    for (int i = 1; i <= RESET_CYCLES; i++) begin
      tick();
      if (i == RESET_CYCLES - 1) chk1({tag, "_rst_hold"}, dut_reset, 1'b1);
    end
    chk1({tag, "_rst_release"}, dut_reset, 1'b0);
    chk1({tag, "_run_clk_en"}, dut_clk_en, 1'b1);
  endtask

  task automatic do_reset();
    tohost = '0; col_ack = 1'b0; load_ack = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    exp_rounds = 0;
    check_reset_phase("rst");
  endtask

  // One full round starting just after the RUN-entry edge (edge 0).
  task automatic do_round(input int p, input int mx_mode, input int d, input bit nxt,
                          input int e, input bit early);
    logic [COV_W-1:0] snap;
    fuzz_en = 1'b1;
    tohost  = '0;
    case (mx_mode)
      0:       max_cycles = '0;
      1:       max_cycles = 64'(p - 1);                 // timeout coincides with pass
      default: max_cycles = 64'(p + $urandom_range(1, 20));
    endcase
    for (int k = 1; k < p; k++) begin
      cov = COV_W'($urandom);
      tick();
    end
    chk1("run_clk_en", dut_clk_en, 1'b1);
    tohost = {$urandom, $urandom};
    tohost[0] = 1'b1;
    tick();
    chk1("pass_clk_gate", dut_clk_en, 1'b0);
    tohost = '0;
    snap = '0;
    for (int k = 1; k <= DRAIN_CYCLES; k++) begin
      cov = COV_W'($urandom);
      if (k == DRAIN_CYCLES) snap = cov;
      if (early && k == 2) col_ack = 1'b1;
      col_next = nxt;
      tick();
      if (k == DRAIN_CYCLES - 1) chk1("col_req_early", col_req, 1'b0);
    end
    chk1("col_req_rise", col_req, 1'b1);
    chkw("col_cov_snap", 64'(col_cov), 64'(snap));
    chk1("collect_clk_en", dut_clk_en, 1'b0);
    if (!early) begin
      for (int j = 0; j < d; j++) begin
        col_ack = 1'b0;
        tick();
      end
      if (d > 0) chk1("col_req_wait", col_req, 1'b1);
    end
    col_ack = 1'b1;
    tick();
    col_ack = 1'b0;
    exp_rounds++;
    chk1("col_req_drop", col_req, 1'b0);
    chkw("round_cnt", 64'(round_cnt), 64'(exp_rounds));
    if (nxt) begin
      chk1("load_req_rise", load_req, 1'b1);
      chk1("load_dut_reset", dut_reset, 1'b1);
      chk1("load_clk_en", dut_clk_en, 1'b0);
      for (int j = 0; j < e; j++) tick();
      load_ack = 1'b1;
      tick();
      load_ack = 1'b0;
      chk1("load_req_drop", load_req, 1'b0);
    end else begin
      chk1("rerun_no_load", load_req, 1'b0);
    end
    chk1("reset_dut_reset", dut_reset, 1'b1);
    chk1("reset_clk_en", dut_clk_en, 1'b1);
    check_reset_phase("round");
  endtask

  // Stall then watchdog irq, finishing with a pass while fuzz_en = 0.
  task automatic stall_wdog();
    int r, c, t, k;
    logic [COV_W-1:0] last;
    fuzz_en = 1'b1; max_cycles = '0; tohost = '0;
    last = cov; c = 0; k = 0;
    r = $urandom_range(0, 40);
    repeat (r) begin
      cov = COV_W'($urandom_range(0, 3));
      k++;
      if (cov != last) c = k;
      last = cov;
      tick();
    end
    t = c + STALL_LIMIT + 1;
    while (k < t - 1) begin k++; tick(); end
    chk1("irq_pre_stall", irq, 1'b0);
    k++; tick();
    chk1("irq_stall", irq, 1'b1);
    cov = cov ^ COV_W'(1);
    k++; tick();
    chk1("irq_stall_lag", irq, 1'b1);
    cov = cov ^ COV_W'(1);
    k++; tick();
    chk1("irq_stall_clear", irq, 1'b0);
    while (k < WDOG_LIMIT) begin
      cov = cov ^ COV_W'(1);
      k++; tick();
    end
    chk1("irq_pre_wdog", irq, 1'b0);
    cov = cov ^ COV_W'(1);
    k++; tick();
    chk1("irq_wdog", irq, 1'b1);
    repeat (4) begin cov = cov ^ COV_W'(1); tick(); end
    chk1("irq_wdog_hold", irq, 1'b1);
    fuzz_en = 1'b0;
    tohost = 64'd1;
    tick();
    chk1("irq_drain_clear", irq, 1'b0);
    chk1("drain_clk_en", dut_clk_en, 1'b0);
    repeat (DRAIN_CYCLES - 1) tick();
    chk1("done_early", done, 1'b0);
    tick();
    chk1("pass_done", done, 1'b1);
    chk1("pass_fail", fail, 1'b0);
    chk1("done_dut_reset", dut_reset, 1'b0);
    chk1("done_clk_en", dut_clk_en, 1'b0);
    col_ack = 1'b1; load_ack = 1'b1; fuzz_en = 1'b1; tohost = '0;
    repeat (5) tick();
    chk1("done_terminal", done, 1'b1);
    chk1("done_no_col_req", col_req, 1'b0);
    col_ack = 1'b0; load_ack = 1'b0;
  endtask

  initial begin
    int seen;
    int m;
    int p;
    cov = COV_W'($urandom);
    tick();
    tick();
    chk1("rst_dut_reset", dut_reset, 1'b1);
    chk1("rst_clk_en", dut_clk_en, 1'b1);
    chk1("rst_irq", irq, 1'b0);
    chk1("rst_col_req", col_req, 1'b0);
    chk1("rst_load_req", load_req, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_fail", fail, 1'b0);
    chkw("rst_col_cov", 64'(col_cov), 64'd0);
    chkw("rst_round_cnt", 64'(round_cnt), 64'd0);
    reset_n = 1'b1;
    check_reset_phase("init");

    do_round(100, 0, 3, 1'b1, 5, 1'b0);
    for (int i = 0; i < 4; i++)
      do_round($urandom_range(2, 150), $urandom_range(0, 2), $urandom_range(0, 4),
               1'($urandom_range(0, 1)), $urandom_range(0, 5), ($urandom_range(0, 3) == 0));

    // Reset pulse while a collect request is pending.
    p = $urandom_range(5, 60);
    fuzz_en = 1'b1; max_cycles = '0; tohost = '0;
    repeat (p - 1) tick();
    tohost = 64'd1;
    tick();
    tohost = '0;
    repeat (DRAIN_CYCLES) tick();
    chk1("pending_col_req", col_req, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk1("async_col_req", col_req, 1'b0);
    chkw("async_round_cnt", 64'(round_cnt), 64'd0);
    chk1("async_dut_reset", dut_reset, 1'b1);
    chk1("async_clk_en", dut_clk_en, 1'b1);
    tick();
    reset_n = 1'b1;
    exp_rounds = 0;
    check_reset_phase("restart");

    stall_wdog();

    // Timeout without pass.
    do_reset();
    max_cycles = 64'd50; fuzz_en = 1'b1; tohost = '0;
    seen = 0;
    for (int k = 1; k <= 50; k++) begin tick(); if (col_req) seen++; end
    chk1("tmo_run", dut_clk_en, 1'b1);
    tick();
    chk1("tmo_drain", dut_clk_en, 1'b0);
    for (int k = 1; k <= DRAIN_CYCLES + 4; k++) begin tick(); if (col_req) seen++; end
    chk1("tmo_done", done, 1'b1);
    chk1("tmo_fail", fail, 1'b1);
    chkw("tmo_col_req_seen", 64'(seen), 64'd0);

    // Pass and timeout together with fuzz_en = 0.
    do_reset();
    m = $urandom_range(10, 60);
    max_cycles = 64'(m); fuzz_en = 1'b0; tohost = '0;
    repeat (m) tick();
    tohost = 64'd1;
    tick();
    tohost = '0;
    repeat (DRAIN_CYCLES) tick();
    chk1("both_done", done, 1'b1);
    chk1("both_fail", fail, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fuzz_round_sequencer.md
# fuzz_round_sequencer

Synthesizable controller that sequences the fuzzing loop around the `TestHarness` DUT: it watches `tohost` and the DUT coverage sum, gates the DUT clock, drives DUT reset, and runs request/acknowledge handshakes with the host-side coverage collector and the memory reloader. It also raises the stall/watchdog interrupt that is forced onto the core's `msip`. It sits beside the `CJ` tohost source at the top of the testbench/FPGA shell and replaces the behavioural fuzz task and coverage monitor.

## Interface
- `COV_W`, 30, width of the coverage sum
- `STALL_LIMIT`, 1000, cycles of unchanged coverage before `irq`
- `WDOG_LIMIT`, 10000, cycles without a pass before `irq`
- `DRAIN_CYCLES`, 4, DUT-clock-off cycles before collection
- `RESET_CYCLES`, 8, DUT reset hold length
- `clock`  in  1  single clock for the block; the DUT clock enable is derived from it
- `reset_n`  in  1  asynchronous, active-low reset
- `fuzz_en`  in  1  1 = loop over rounds; 0 = stop after the first pass
- `max_cycles`  in  64  run-cycle limit per round; 0 = unlimited
- `tohost`  in  64  DUT tohost word; bit 0 = pass
- `cov`  in  COV_W  DUT coverage sum
- `dut_clk_en`  out  1  DUT clock enable
- `dut_reset`  out  1  active-high DUT reset
- `irq`  out  1  stall/watchdog interrupt
- `col_req`  out  1  collect request
- `col_cov`  out  COV_W  coverage snapshot, valid while `col_req` is high
- `col_ack`  in  1  collector done
- `col_next`  in  1  sampled with `col_ack`; 1 = load a new testcase
- `load_req`  out  1  memory reload request
- `load_ack`  in  1  reload done
- `done`  out  1  terminal state reached
- `fail`  out  1  terminal because of timeout; valid when `done` is high
- `round_cnt`  out  32  completed rounds

## Operation
- States: RESET, RUN, DRAIN, COLLECT, LOAD, DONE.
- Values while `reset_n` is low:
  - state = RESET.
  - `dut_reset` = 1, `dut_clk_en` = 1.
  - `irq`, `col_req`, `load_req`, `done`, `fail` = 0.
  - `col_cov` = 0, `round_cnt` = 0.
  - All internal counters = 0.
- RESET: `dut_reset` = 1, `dut_clk_en` = 1. Holds for RESET_CYCLES cycles, then goes to RUN. Clears the run, stall and watchdog counters.
- RUN: `dut_reset` = 0, `dut_clk_en` = 1.
  - Run counter: +1 per cycle.
  - Watchdog: +1 per cycle.
  - Stall counter: +1 per cycle while `cov` equals the registered previous value. On any change it clears and the previous value reloads from `cov`.
  - All counters saturate at all-ones.
  - `irq` is registered: it is 1 when stall counter ≥ STALL_LIMIT or watchdog ≥ WDOG_LIMIT.
- Exits from RUN:
  - `tohost[0]` = 1 → DRAIN; pass recorded.
  - Else `max_cycles` ≠ 0 and run counter > `max_cycles` → DRAIN; fail recorded.
  - Pass has priority when both occur in the same cycle.
- DRAIN: `dut_clk_en` = 0, `irq` = 0. After DRAIN_CYCLES cycles:
  - fail → DONE with `fail` = 1;
  - pass and `fuzz_en` = 0 → DONE with `fail` = 0;
  - pass and `fuzz_en` = 1 → COLLECT, with `col_cov` ← `cov`.
- COLLECT: `col_req` = 1, `dut_clk_en` = 0. On `col_ack` = 1:
  - `col_next` = 1 → LOAD;
  - `col_next` = 0 → RESET (same image rerun).
  - In both cases `round_cnt` +1, wrapping modulo 2^32.
- LOAD: `load_req` = 1, `dut_reset` = 1, `dut_clk_en` = 0. On `load_ack` = 1 → RESET.
- DONE: `done` = 1, `dut_clk_en` = 0, `dut_reset` = 0. Terminal; only `reset_n` leaves it.
- Handshakes:
  - A request stays high until its ack is sampled high.
  - The request drops the cycle after that sample.
  - An ack seen while the request is low is ignored.
  - An ack already high on the first cycle of the request is accepted on that cycle.
- `fuzz_en` and `max_cycles` are sampled every cycle; changing them mid-round affects that round.
- `reset_n` asserted in any state immediately forces the reset values. A pending handshake is abandoned; the host must tolerate a request vanishing.

## Timing
- All outputs are registered.
- `tohost[0]` sampled at edge N → `dut_clk_en` = 0 from edge N+1.
- Collect path from pass sample to `col_req` high: 1 + DRAIN_CYCLES edges.
- Path from `col_ack` (with `col_next` = 0) to `dut_reset` deasserted: 1 + RESET_CYCLES edges.
- `irq` rises one cycle after the counter reaches its limit. It falls at the latest on the first DRAIN or RESET cycle.
- Watchdog and stall counters clear on entry to DRAIN and stay clear until RUN.

## Test plan
- `reset_n` low, then high; `tohost` = 0; `fuzz_en` = 1 → all outputs at their reset values; `dut_reset` deasserts after 8 cycles; `round_cnt` = 0.
- `tohost` = 1 at run cycle 100; `fuzz_en` = 1; `col_ack` after 3 cycles with `col_next` = 1; `load_ack` after 5 cycles →
  - `dut_clk_en` low 1 cycle after the pass;
  - `col_req` high 5 cycles after the pass, with `col_cov` equal to the snapshot;
  - `load_req` pulse follows; RESET lasts 8 cycles;
  - `round_cnt` = 1.
- `cov` held constant, `tohost` = 0 → `irq` = 1 at run cycle 1001. A `cov` change then clears the stall term; `irq` stays high if the watchdog ≥ 10000.
- `max_cycles` = 50 with no pass → DRAIN at cycle 51; then `done` = 1, `fail` = 1, `col_req` never asserted.
- `tohost[0]` and the timeout in the same cycle with `fuzz_en` = 0 → `done` = 1, `fail` = 0.
- `reset_n` pulsed low while `col_req` = 1 → `col_req` = 0 immediately; the sequence restarts from RESET; `round_cnt` = 0.
